avalon_sram_responder: RTL and testbench

//  Avalon-MM responder sitting directly downstream of the CVA5 Avalon master (local bus stage).

---
 rtl/avalon_sram_responder_pkg.sv | 14 +
 rtl/avalon_sram_responder.sv | 123 ++++++++++++
 tb/tb_avalon_sram_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/avalon_sram_responder_pkg.sv
// Shared types and limits for the Avalon-MM SRAM responder.
// Imported by the responder top; holds the FSM state encoding and the latency ceiling.
package avalon_sram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } avalon_sram_state_t;

    localparam int AVALON_SRAM_MAX_LATENCY = 4;

endpackage

// File: rtl/avalon_sram_responder.sv
// Avalon-MM responder bridging the master onto a single-port synchronous SRAM.
// Decodes the address window, issues one SRAM strobe per access and stalls until it completes.
module avalon_sram_responder
    import avalon_sram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h6000_0000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  read,
    input  logic                  write,
    input  logic [3:0]            byteenable,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int CNT_W   = $clog2(READ_LATENCY + 1);
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    if (READ_LATENCY < 1 || READ_LATENCY > AVALON_SRAM_MAX_LATENCY) begin : g_bad_latency
        $error("avalon_sram_responder: READ_LATENCY out of range");
    end
    if (BASE_ADDR[TAG_LSB-1:0] != '0) begin : g_bad_base
        $error("avalon_sram_responder: BASE_ADDR not aligned to the window size");
    end

    avalon_sram_state_t    state_q;
    logic                  is_read_q;
    logic                  hit_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [31:0]           readdata_q;
    logic                  waitrequest_q;
    logic                  mem_en_q;
    logic [3:0]            mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic hit;
    assign hit = (addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // Byte offset within a word is irrelevant to a word-wide SRAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            hit_q         <= 1'b0;
            cnt_q         <= '0;
            readdata_q    <= '0;
            waitrequest_q <= 1'b1;
            mem_en_q      <= 1'b0;
            mem_we_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking defaults here make the SRAM strobe a one-cycle pulse; later
            // assignments in the same block override them without creating ordering races.
            mem_en_q <= 1'b0;
            mem_we_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (read || write) begin
                        is_read_q   <= read;
                        hit_q       <= hit;
                        mem_en_q    <= hit;
                        mem_we_q    <= (hit && !read) ? byteenable : 4'h0;
                        mem_addr_q  <= addr[TAG_LSB-1:2];
                        mem_wdata_q <= writedata;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_read_q && hit_q) begin
                        cnt_q   <= CNT_W'(READ_LATENCY - 1);
                        state_q <= WAIT;
                    end else begin
                        if (is_read_q) readdata_q <= ERR_DATA;
                        waitrequest_q <= 1'b0;
                        state_q       <= DONE;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        readdata_q    <= mem_rdata;
                        waitrequest_q <= 1'b0;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    waitrequest_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Simultaneous read and write is illegal; the read is served and the write dropped.
    a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst)
        !(state_q == IDLE && read && write));

    assign readdata    = readdata_q;
    assign waitrequest = waitrequest_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Self-checking bench: two responders (read latency 1 and 3) behind a bench master,
// each backed by a behavioural SRAM, checked against a word-level reference memory.
module tb_avalon_sram_responder;

    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    bit          sel;
    logic        m_read, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    logic        rq1, wq1, rq3, wq3;
    logic [31:0] rd1, rd3, wd1, wd3, mr1, mr3;
    logic        wr1, wr3, en1, en3;
    logic [3:0]  we1, we3;
    logic [9:0]  ma1, ma3;

    logic [31:0] smem1 [1024];
    logic [31:0] smem3 [1024];
    logic [31:0] rpipe1;
    logic [31:0] rpipe3 [3];
    logic [31:0] ref_mem [2][1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rq1 = m_read  & ~sel;
    assign wq1 = m_write & ~sel;
    assign rq3 = m_read  &  sel;
    assign wq3 = m_write &  sel;
    assign mr1 = rpipe1;
    assign mr3 = rpipe3[2];

    avalon_sram_responder #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .addr(m_addr), .read(rq1), .write(wq1),
        .byteenable(m_be), .writedata(m_wdata), .readdata(rd1), .waitrequest(wr1),
        .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(mr1)
    );

    avalon_sram_responder #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .addr(m_addr), .read(rq3), .write(wq3),
        .byteenable(m_be), .writedata(m_wdata), .readdata(rd3), .waitrequest(wr3),
        .mem_en(en3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(wd3), .mem_rdata(mr3)
    );

    // Behavioural SRAMs: read data is valid exactly READ_LATENCY cycles after the strobe.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) smem1[i] <= '0;
        end else if (en1) begin
            for (int b = 0; b < 4; b++) if (we1[b]) smem1[ma1][8*b +: 8] <= wd1[8*b +: 8];
        end
        rpipe1 <= (en1 && we1 == 4'h0) ? smem1[ma1] : JUNK;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) smem3[i] <= '0;
        end else if (en3) begin
            for (int b = 0; b < 4; b++) if (we3[b]) smem3[ma3][8*b +: 8] <= wd3[8*b +: 8];
        end
        rpipe3[0] <= (en3 && we3 == 4'h0) ? smem3[ma3] : JUNK;
        rpipe3[1] <= rpipe3[0];
        rpipe3[2] <= rpipe3[1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access from just after a rising edge; cycle 0 is the current cycle.
    task automatic access(input bit s, input bit is_wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          output logic [31:0] rdata, output int lat, output int en_cnt,
                          output int en_cyc, output logic [9:0] en_addr,
                          output logic [3:0] en_we, output logic wr_after);
        sel = s; m_addr = a; m_be = be; m_wdata = d;
        m_read = !is_wr; m_write = is_wr;
        lat = -1; en_cnt = 0; en_cyc = -1; en_addr = '0; en_we = '0; rdata = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s ? en3 : en1) begin
                en_cnt++; en_cyc = c;
                en_addr = s ? ma3 : ma1;
                en_we   = s ? we3 : we1;
            end
            if (!(s ? wr3 : wr1)) begin
                lat = c; rdata = s ? rd3 : rd1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m_read = 1'b0; m_write = 1'b0;
        wr_after = s ? wr3 : wr1;
    endtask

    // Runs one access and checks it against the reference memory and timing rules.
    task automatic run_op(input string tag, input bit s, input bit is_wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        logic [31:0] rdata, exp_rd;
        logic [9:0]  en_addr, idx;
        logic [3:0]  en_we;
        logic        wr_after;
        int          lat, en_cnt, en_cyc, rl;
        bit          hit;
        hit = (a[31:12] == 20'h60000);
        idx = a[11:2];
        rl  = s ? 3 : 1;
        exp_rd = hit ? ref_mem[s][idx] : ERR;
        access(s, is_wr, a, be, d, rdata, lat, en_cnt, en_cyc, en_addr, en_we, wr_after);
        check({tag, ".lat"}, lat, (hit && !is_wr) ? 2 + rl : 2);
        check({tag, ".en_cnt"}, en_cnt, hit ? 1 : 0);
        if (hit) begin
            check({tag, ".en_cyc"}, en_cyc, 1);
            check({tag, ".en_addr"}, {22'd0, en_addr}, {22'd0, idx});
            check({tag, ".en_we"}, {28'd0, en_we}, is_wr ? {28'd0, be} : 32'd0);
        end
        if (!is_wr) check({tag, ".rdata"}, rdata, exp_rd);
        check({tag, ".wr_after"}, {31'd0, wr_after}, 32'd1);
        if (hit && is_wr)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[s][idx][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        logic [31:0] a;
        int          en_seen;
        rst = 1'b1; mem_clr = 1'b1; sel = 1'b0;
        m_read = 1'b0; m_write = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) ref_mem[s][i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.waitrequest", {31'd0, wr1}, 32'd1);
        check("reset.readdata", rd1, 32'd0);
        check("reset.mem_en", {31'd0, en1}, 32'd0);
        check("reset.mem_we", {28'd0, we1}, 32'd0);
        check("reset.mem_addr", {22'd0, ma1}, 32'd0);
        check("reset.mem_wdata", wd1, 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        // Full write then read-back, latency 1
        run_op("t1.wr", 0, 1, 32'h6000_0010, 4'hF, 32'h1234_5678);
        run_op("t1.rd", 0, 0, 32'h6000_0010, 4'h0, 32'h0);
        // Partial write over the same word
        run_op("t2.wr", 0, 1, 32'h6000_0011, 4'b0010, 32'h0000_AB00);
        run_op("t2.rd", 0, 0, 32'h6000_0010, 4'h0, 32'h0);
        check("t2.model", ref_mem[0][4], 32'h1234_AB78);
        // Latency 3 responder
        run_op("t3.wr", 1, 1, 32'h6000_0010, 4'hF, 32'hCAFE_F00D);
        run_op("t3.rd", 1, 0, 32'h6000_0010, 4'h0, 32'h0);
        // Out-of-window read and write; top word of the window
        run_op("t4.rd_miss", 0, 0, 32'h5000_0000, 4'h0, 32'h0);
        run_op("t4.wr_miss", 0, 1, 32'h5000_0000, 4'hF, 32'h5555_AAAA);
        run_op("t4.rd_after_miss", 0, 0, 32'h6000_0000, 4'h0, 32'h0);
        run_op("t4.wr_top", 0, 1, 32'h6000_0FFC, 4'hF, 32'hA5A5_0FFC);
        run_op("t4.rd_top", 0, 0, 32'h6000_0FFF, 4'h0, 32'h0);

        // Reset asserted while the latency-3 read sits in WAIT
        sel = 1'b1; m_addr = 32'h6000_0010; m_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5.in_wait", {31'd0, wr3}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5.rst_wait", {31'd0, wr3}, 32'd1);
        check("t5.rst_en", {31'd0, en3}, 32'd0);
        check("t5.rst_rdata", rd3, 32'd0);
        @(posedge clk); #1;
        m_read = 1'b0;
        en_seen = 0;
        repeat (2) begin @(negedge clk); if (en3) en_seen++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (en3 || !wr3) en_seen++; end
        check("t5.no_activity", en_seen, 0);
        @(posedge clk); #1;
        run_op("t5.rd_after", 1, 0, 32'h6000_0010, 4'h0, 32'h0);

        // Randomised back-to-back traffic on both responders
        for (int n = 0; n < 100; n++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                a = $urandom;
                if (a[31:12] == 20'h60000) a[31] = ~a[31];
            end else if (r == 1) begin
                a = 32'h6000_0FFC | $urandom_range(0, 3);
            end else begin
                a = 32'h6000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            end
            run_op($sformatf("t6.%0d", n), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   a, 4'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
